// File: rtl/byte_serial_alu32.sv
// Byte-serial 32-bit ALU: one 8-bit slice per clock, LSB slice first, with a registered carry
// between slices. Define OVERFLOW_FLAG_EN to add the signed-overflow output for ADD/SUB.
module byte_serial_alu32 #(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALU_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
`ifdef OVERFLOW_FLAG_EN
  output logic             overflow,
`endif
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [3:0]         op_reg;
  logic [IDX_W-1:0]   idx;
  logic               carry;

  logic [SLICE_W-1:0] a_slices [NSLICE];
  logic [SLICE_W-1:0] b_slices [NSLICE];

  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign a_slices[gi] = a_reg[gi*SLICE_W +: SLICE_W];
      assign b_slices[gi] = b_reg[gi*SLICE_W +: SLICE_W];
    end
  endgenerate

  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W-1:0] b_eff;
  logic [SLICE_W:0]   sum;
  logic [SLICE_W-1:0] sl_res;
  logic               sl_carry;
  logic [WIDTH-1:0]   result_next;
  logic               last;

  always_comb begin
    a_sl     = a_slices[idx];
    b_sl     = b_slices[idx];
    b_eff    = (op_reg == OP_SUB) ? ~b_sl : b_sl;
    sum      = {1'b0, a_sl} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, carry};
    sl_res   = '0;
    sl_carry = 1'b0;
    case (op_reg)
      OP_AND:         sl_res = a_sl & b_sl;
      OP_OR:          sl_res = a_sl | b_sl;
      OP_XOR:         sl_res = a_sl ^ b_sl;
      OP_ADD, OP_SUB: begin
        sl_res   = sum[SLICE_W-1:0];
        sl_carry = sum[SLICE_W];
      end
      default: ;
    endcase
    result_next = result;
    result_next[idx*SLICE_W +: SLICE_W] = sl_res;
    last = (idx == IDX_W'(NSLICE - 1));
  end

`ifdef OVERFLOW_FLAG_EN
  // Carry into the slice MSB recovered from the sum bit: s = a ^ b ^ cin.
  logic msb_cin;
  always_comb begin
    msb_cin = a_sl[SLICE_W-1] ^ b_eff[SLICE_W-1] ^ sum[SLICE_W-1];
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= a;
            b_reg    <= b;
            op_reg   <= ALU_op;
            carry    <= (ALU_op == OP_SUB);
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          result <= result_next;
          carry  <= sl_carry;
          if (last) begin
            idx       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
            carry_out <= sl_carry;
            zero      <= (result_next == '0);
`ifdef OVERFLOW_FLAG_EN
            overflow  <= ((op_reg == OP_ADD) || (op_reg == OP_SUB)) && (msb_cin ^ sl_carry);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_alu32.sv
// Randomized self-checking bench for byte_serial_alu32 against a whole-word arithmetic model.
module tb_byte_serial_alu32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  ALU_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry_out;
  logic        zero;
`ifdef OVERFLOW_FLAG_EN
  logic        overflow;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  byte_serial_alu32 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ALU_op    (ALU_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
`ifdef OVERFLOW_FLAG_EN
    .overflow  (overflow),
`endif
    .zero      (zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Whole-word reference: 33-bit arithmetic, signed overflow from operand/result signs.
  task automatic model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op,
                       output logic [31:0] r, output logic c, output logic z, output logic v);
    logic [32:0] s;
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0011: r = x ^ y;
      4'b0010: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[31:0]; c = s[32];
        v = (x[31] == y[31]) && (r[31] != x[31]);
      end
      4'b0110: begin
        s = {1'b0, x} + {1'b0, ~y} + 33'd1;
        r = s[31:0]; c = s[32];
        v = (x[31] != y[31]) && (r[31] != x[31]);
      end
      default: ;
    endcase
    z = (r == 32'd0);
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic [3:0] top,
                        input int bp);
    logic [31:0] er;
    logic ec, ez, ev;
    int lat;
    model(ta, tb_, top, er, ec, ez, ev);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    a = ta; b = tb_; ALU_op = top; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    lat = 1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; ALU_op = 4'($urandom);
    check("in_ready_busy", in_ready, 0);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat - 1, 4);
    check("result", result, er);
    check("carry_out", carry_out, ec);
    check("zero", zero, ez);
`ifdef OVERFLOW_FLAG_EN
    check("overflow", overflow, ev);
`endif
    $display("op=%b a=%08h b=%08h result=%08h carry=%0b zero=%0b bp=%0d",
             top, ta, tb_, result, carry_out, zero, bp);
    for (int k = 0; k < bp; k++) begin
      in_valid = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (bp > 0) begin
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_result", result, er);
      check("bp_carry", carry_out, ec);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("handoff_valid", out_valid, 0);
    check("handoff_ready", in_ready, 1);
  endtask

  logic [3:0] legal_ops [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110};

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    bit          saw_valid;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ALU_op = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_carry", carry_out, 0);
    check("rst_zero", zero, 0);
    reset_n = 1'b1;

    run_op(32'h0000_00FF, 32'h0000_0001, 4'b0010, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 4'b0010, 0);
    run_op(32'h0000_0005, 32'h0000_0007, 4'b0110, 0);
    run_op(32'h0000_0007, 32'h0000_0007, 4'b0110, 0);
    run_op(32'h8000_0000, 32'h0000_0001, 4'b0110, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 0);
    run_op(32'hF0F0_1234, 32'h0FF0_FF00, 4'b0000, 0);
    run_op(32'hF0F0_1234, 32'h0FF0_FF00, 4'b0001, 0);
    run_op(32'hF0F0_1234, 32'h0FF0_FF00, 4'b0011, 0);
    run_op(32'hF0F0_1234, 32'h0FF0_FF00, 4'b1111, 0);
    run_op(32'h1234_5678, 32'h0101_0101, 4'b0010, 6);

    // Abort: reset lands on the second BUSY edge.
    @(negedge clk);
    a = 32'h1111_1111; b = 32'h2222_2222; ALU_op = 4'b0010; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("abort_out_valid", out_valid, 0);
    check("abort_result", result, 0);
    check("abort_carry", carry_out, 0);
    check("abort_zero", zero, 0);
    check("abort_in_ready", in_ready, 1);
    saw_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("abort_no_valid", saw_valid, 0);
    run_op(32'd3, 32'd4, 4'b0010, 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: ra = 32'h0;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 5) == 0) ? ra : $urandom;
      if ($urandom_range(0, 5) == 0) rop = 4'($urandom_range(7, 15));
      else rop = legal_ops[$urandom_range(0, 4)];
      run_op(ra, rb, rop, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
